mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/rr_picker.sv | 38 +++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    // Parameter defaults used by mem_arbiter
    localparam int N_REQ_DEF   = 4;
    localparam int QUANTUM_DEF = 2;
    localparam int HP_EN_DEF   = 1;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of elig searching upward from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; vld=0 when no bit of elig is set.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             vld,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0]   cand_w;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest eligible index wins
    always_comb begin
        vld    = 1'b0;
        idx    = '0;
        cand_w = '0;
        cand   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand_w = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand_w >= N_W) begin
                cand_w = cand_w - N_W;
            end
            cand = cand_w[IDX_W-1:0];
            if (elig[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: round-robin tenures bounded by QUANTUM, optional preempting requester 0.
// Latency: grant/owner/busy/preempt registered, one cycle after the deciding inputs.
// Backpressure: requesters hold req level until granted; release is back-to-back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int QUANTUM = QUANTUM_DEF,
    parameter int HP_EN   = HP_EN_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     preempt
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

    generate
        if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
            $error("mem_arbiter: N_REQ must be in 2..16");
        end
        if (QUANTUM < 1 || QUANTUM > 255) begin : g_bad_quantum
            $error("mem_arbiter: QUANTUM must be in 1..255");
        end
        if (HP_EN != 0 && HP_EN != 1) begin : g_bad_hp_en
            $error("mem_arbiter: HP_EN must be 0 or 1");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               preempt_q, preempt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               req0_q, req0_d;

    logic [N_REQ-1:0]   rr_elig;
    logic               rr_vld;
    logic [IDX_W-1:0]   rr_idx;
    logic               hp_req;
    logic               hp_new;
    logic               release_c;
    logic               take;
    logic               take_rr;
    logic               go_idle;
    logic [IDX_W-1:0]   win;

    // Eligibility for the round-robin search and release/priority conditions
    always_comb begin
        hp_req    = (HP_EN != 0) && req[0];
        // A request from 0 carried over from its own tenure waits for the next
        // release instead of cutting the following tenure short.
        hp_new    = hp_req && !req0_q;
        release_c = done[owner_q] || !req[owner_q] || (cnt_q == CNT_MAX);
        rr_elig   = req;
        if (HP_EN != 0) begin
            rr_elig[0] = 1'b0;
        end
        if (state_q == GRANT) begin
            rr_elig[owner_q] = 1'b0;
        end
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .elig (rr_elig),
        .ptr  (ptr_q),
        .vld  (rr_vld),
        .idx  (rr_idx)
    );

    // Next-state decision: new grant, hold, preempt or return to idle
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        req0_d    = req[0];
        take      = 1'b0;
        take_rr   = 1'b0;
        go_idle   = 1'b0;
        win       = '0;

        case (state_q)
            IDLE: begin
                if (hp_req) begin
                    take = 1'b1;
                end else if (rr_vld) begin
                    take    = 1'b1;
                    take_rr = 1'b1;
                    win     = rr_idx;
                end
            end
            GRANT: begin
                if (release_c) begin
                    if (hp_req && (owner_q != '0)) begin
                        take = 1'b1;
                    end else if (rr_vld) begin
                        take    = 1'b1;
                        take_rr = 1'b1;
                        win     = rr_idx;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hp_new && (owner_q != '0)) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (take) begin
            state_d      = GRANT;
            grant_d      = '0;
            grant_d[win] = 1'b1;
            owner_d      = win;
            busy_d       = 1'b1;
            cnt_d        = CNT_ONE;
            // Only round-robin wins advance the rotation; priority wins of 0 leave it intact
            if (take_rr) begin
                ptr_d = win;
            end
        end else if (go_idle) begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= PTR_RST;
            req0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            req0_q    <= req0_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
